// File: rtl/sd_card_fsm.sv
// SD card command-layer responder: tracks card state, RCA, APP_CMD and status bits, and drives the response and data engines.
// Define SD_CARD_BUSY_EN to build the PRG busy period after a multi-block write.
module sd_card_fsm #(
    parameter logic [15:0]  RCA             = 16'h1234,
    parameter int unsigned  INIT_POLLS      = 3,
    parameter logic [31:0]  CAPACITY_BLOCKS = 32'd1024,
    parameter logic [119:0] CSD             = 120'h400E_0032_5B59_0000_077F_800A_4000_E5,
    parameter logic [119:0] CID             = 120'h0353_4453_4433_3247_8012_3456_7801_23,
    parameter int unsigned  PRG_CYCLES      = 16
) (
    input  logic         iclk,
    input  logic         irst_n,
    input  logic         icmd_valid,
    input  logic [5:0]   icmd_index,
    input  logic [31:0]  icmd_arg,
    input  logic         icrc_ok,
    input  logic         iresp_busy,
    input  logic         idata_done,
    output logic         orecv_ready,
    output logic         oresp_start,
    output logic         oresp_long,
    output logic [5:0]   oresp_index,
    output logic [31:0]  oresp_arg,
    output logic [119:0] oresp_r2,
    output logic         odata_start,
    output logic         odata_mode,
    output logic [31:0]  oblock_addr,
    output logic         ostop_d,
    output logic         obusy,
    output logic [3:0]   ocard_state
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0, ST_READY = 4'd1, ST_IDENT = 4'd2, ST_STBY = 4'd3, ST_TRAN = 4'd4,
        ST_DATA  = 4'd5, ST_RCV   = 4'd6, ST_PRG   = 4'd7, ST_INA  = 4'd8
    } state_e;

    typedef enum logic [2:0] {RSP_NONE, RSP_R1, RSP_R2, RSP_R3, RSP_R6, RSP_R7} rsp_e;

    state_e         state_q, state_d;
    logic           app_cmd_q, app_cmd_d;
    logic [7:0]     poll_cnt_q, poll_cnt_d;
    logic           crc_err_q, crc_err_d;
    logic           illegal_q, illegal_d;
    logic           resp_start_q, resp_start_d;
    logic           resp_long_q, resp_long_d;
    logic [5:0]     resp_index_q, resp_index_d;
    logic [31:0]    resp_arg_q, resp_arg_d;
    logic [119:0]   resp_r2_q, resp_r2_d;
    logic           data_start_q, data_start_d;
    logic           data_mode_q, data_mode_d;
    logic [31:0]    block_addr_q, block_addr_d;
    logic           stop_pulse_q, stop_pulse_d;
`ifdef SD_CARD_BUSY_EN
    logic [15:0]    prg_cnt_q, prg_cnt_d;
`endif

    logic           cmd_accept, is_acmd, rca_match, in_range, out_of_range;
    rsp_e           rsp_kind;
    logic [31:0]    status_w, ocr_w;
    logic [119:0]   r2_w;

    assign cmd_accept = icmd_valid && !iresp_busy && (state_q != ST_INA);
    assign is_acmd    = app_cmd_q && (icmd_index == 6'd41 || icmd_index == 6'd23);
    assign rca_match  = (icmd_arg[31:16] == RCA);
    assign in_range   = (icmd_arg < CAPACITY_BLOCKS);

    // NOTE: reset is sampled on the clock edge; every flop, including the response fields, clears to 0.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q      <= ST_IDLE;
            app_cmd_q    <= 1'b0;
            poll_cnt_q   <= '0;
            crc_err_q    <= 1'b0;
            illegal_q    <= 1'b0;
            resp_start_q <= 1'b0;
            resp_long_q  <= 1'b0;
            resp_index_q <= '0;
            resp_arg_q   <= '0;
            resp_r2_q    <= '0;
            data_start_q <= 1'b0;
            data_mode_q  <= 1'b0;
            block_addr_q <= '0;
            stop_pulse_q <= 1'b0;
`ifdef SD_CARD_BUSY_EN
            prg_cnt_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            app_cmd_q    <= app_cmd_d;
            poll_cnt_q   <= poll_cnt_d;
            crc_err_q    <= crc_err_d;
            illegal_q    <= illegal_d;
            resp_start_q <= resp_start_d;
            resp_long_q  <= resp_long_d;
            resp_index_q <= resp_index_d;
            resp_arg_q   <= resp_arg_d;
            resp_r2_q    <= resp_r2_d;
            data_start_q <= data_start_d;
            data_mode_q  <= data_mode_d;
            block_addr_q <= block_addr_d;
            stop_pulse_q <= stop_pulse_d;
`ifdef SD_CARD_BUSY_EN
            prg_cnt_q    <= prg_cnt_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d      = state_q;
        app_cmd_d    = app_cmd_q;
        poll_cnt_d   = poll_cnt_q;
        crc_err_d    = crc_err_q;
        illegal_d    = illegal_q;
        resp_start_d = 1'b0;
        resp_long_d  = resp_long_q;
        resp_index_d = resp_index_q;
        resp_arg_d   = resp_arg_q;
        resp_r2_d    = resp_r2_q;
        data_start_d = 1'b0;
        data_mode_d  = data_mode_q;
        block_addr_d = block_addr_q;
        stop_pulse_d = 1'b0;
`ifdef SD_CARD_BUSY_EN
        prg_cnt_d    = prg_cnt_q;
`endif
        rsp_kind     = RSP_NONE;
        out_of_range = 1'b0;
        ocr_w        = '0;
        r2_w         = CID;
        status_w     = '0;

        if (state_q == ST_DATA && data_mode_q && idata_done) state_d = ST_TRAN;
`ifdef SD_CARD_BUSY_EN
        if (state_q == ST_PRG) begin
            if (prg_cnt_q == 16'(PRG_CYCLES - 1)) state_d = ST_TRAN;
            else prg_cnt_d = prg_cnt_q + 16'd1;
        end
`endif

        if (cmd_accept && !icrc_ok) begin
            crc_err_d = 1'b1;
        end else if (cmd_accept) begin
            app_cmd_d = 1'b0;
            case (icmd_index)
                6'd0: begin
                    state_d    = ST_IDLE;
                    poll_cnt_d = '0;
                    crc_err_d  = 1'b0;
                    illegal_d  = 1'b0;
                end
                6'd8:  if (state_q == ST_IDLE) rsp_kind = RSP_R7; else illegal_d = 1'b1;
                6'd55: begin
                    rsp_kind  = RSP_R1;
                    app_cmd_d = 1'b1;
                end
                6'd41: if (is_acmd && (state_q == ST_IDLE || state_q == ST_READY)) begin
                    rsp_kind = RSP_R3;
                    if (icmd_arg[21:20] == 2'b00) begin
                        state_d = ST_INA;
                    end else begin
                        ocr_w[21:20] = 2'b11;
                        if (poll_cnt_q == 8'(INIT_POLLS)) begin
                            ocr_w[31] = 1'b1;
                            state_d   = ST_READY;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 8'd1;
                        end
                    end
                end else illegal_d = 1'b1;
                6'd2: if (state_q == ST_READY) begin
                    rsp_kind = RSP_R2;
                    state_d  = ST_IDENT;
                end else illegal_d = 1'b1;
                6'd3: if (state_q == ST_IDENT || state_q == ST_STBY) begin
                    rsp_kind = RSP_R6;
                    state_d  = ST_STBY;
                end else illegal_d = 1'b1;
                6'd9: if (state_q != ST_STBY) illegal_d = 1'b1;
                      else if (rca_match) begin
                          rsp_kind = RSP_R2;
                          r2_w     = CSD;
                      end
                6'd7: if (state_q != ST_STBY) illegal_d = 1'b1;
                      else if (rca_match) begin
                          rsp_kind = RSP_R1;
                          state_d  = ST_TRAN;
                      end
                6'd6: if (state_q == ST_TRAN) begin
                    rsp_kind     = RSP_R1;
                    state_d      = ST_DATA;
                    data_start_d = 1'b1;
                    data_mode_d  = 1'b1;
                    block_addr_d = '0;
                end else illegal_d = 1'b1;
                6'd18, 6'd25: if (state_q == ST_TRAN) begin
                    rsp_kind     = RSP_R1;
                    out_of_range = !in_range;
                    if (in_range) begin
                        block_addr_d = icmd_arg;
                        if (icmd_index == 6'd18) begin
                            state_d      = ST_DATA;
                            data_start_d = 1'b1;
                            data_mode_d  = 1'b0;
                        end else begin
                            state_d = ST_RCV;
                        end
                    end
                end else illegal_d = 1'b1;
                6'd23: if (is_acmd && state_q == ST_TRAN) rsp_kind = RSP_R1; else illegal_d = 1'b1;
                6'd12: if (state_q == ST_DATA) begin
                    rsp_kind     = RSP_R1;
                    stop_pulse_d = 1'b1;
                    state_d      = ST_TRAN;
                end else if (state_q == ST_RCV) begin
                    rsp_kind = RSP_R1;
`ifdef SD_CARD_BUSY_EN
                    state_d   = ST_PRG;
                    prg_cnt_d = '0;
`else
                    state_d   = ST_TRAN;
`endif
                end else illegal_d = 1'b1;
                6'd13: if (rca_match) rsp_kind = RSP_R1;
                6'd15: if (rca_match) state_d = ST_INA;
                default: illegal_d = 1'b1;
            endcase
        end

        status_w[31]   = out_of_range;
        status_w[23]   = crc_err_q;
        status_w[22]   = illegal_q;
        status_w[12:9] = state_q;
        status_w[8]    = (state_q == ST_TRAN) || (state_q == ST_RCV);
        status_w[5]    = (icmd_index == 6'd55) || is_acmd;

        // R1 and R6 carry the error bits, so reporting them clears them.
        case (rsp_kind)
            RSP_R1, RSP_R6: begin
                resp_start_d = 1'b1;
                resp_long_d  = 1'b0;
                resp_index_d = icmd_index;
                resp_arg_d   = (rsp_kind == RSP_R1) ? status_w
                             : {RCA, status_w[23], status_w[22], status_w[19], status_w[12:0]};
                crc_err_d    = 1'b0;
                illegal_d    = 1'b0;
            end
            RSP_R2: begin
                resp_start_d = 1'b1;
                resp_long_d  = 1'b1;
                resp_index_d = 6'h3F;
                resp_r2_d    = r2_w;
            end
            RSP_R3: begin
                resp_start_d = 1'b1;
                resp_long_d  = 1'b0;
                resp_index_d = 6'h3F;
                resp_arg_d   = ocr_w;
            end
            RSP_R7: begin
                resp_start_d = 1'b1;
                resp_long_d  = 1'b0;
                resp_index_d = icmd_index;
                resp_arg_d   = {20'd0, icmd_arg[11:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        ocard_state = state_q;
        orecv_ready = (state_q == ST_RCV);
        oresp_start = resp_start_q;
        oresp_long  = resp_long_q;
        oresp_index = resp_index_q;
        oresp_arg   = resp_arg_q;
        oresp_r2    = resp_r2_q;
        odata_start = data_start_q;
        odata_mode  = data_mode_q;
        oblock_addr = block_addr_q;
        ostop_d     = stop_pulse_q;
`ifdef SD_CARD_BUSY_EN
        obusy       = (state_q == ST_PRG);
`else
        obusy       = 1'b0;
`endif
    end

endmodule
